// File: rtl/skeleton_writeback.sv
// ---------------------------------------------------------------------------
// skeleton_writeback
//
// Downstream stage of the convolutional mask unit. Collects one pass of the
// mask result stream into a local N*N frame buffer, counts how many pixels
// changed versus the previous pass, and reports pass completion, convergence
// and the number of completed passes. A registered read port lets the loader
// re-stream the frame for the next thinning iteration.
//
// Optional feature (compile-time macro WB_BINARIZE_EN):
//   defined   : accepted pixels are stored as 8'hFF if nonzero, else 8'h00,
//               and the change compare uses the binarized value.
//   undefined : pixels are stored and compared unchanged.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start_pass     in   one-cycle pulse, arms collection of a new pass (IDLE only)
//   in_valid       in   result-stream enable
//   in_addr        in   result pixel address   [bitSize:0]
//   in_data        in   result pixel value     [7:0]
//   rd_addr        in   frame read address     [bitSize:0]
//   rd_data        out  frame read data, one-cycle latency, 0 when out of range
//   busy           out  high while ARMED or COLLECT
//   pass_done      out  one-cycle pulse at end of pass
//   changed_count  out  pixels changed in the last completed pass (saturating)
//   converged      out  last completed pass changed no pixel
//   iter_count     out  completed passes since reset (saturates at 255)
//   iter_limit_hit out  iter_count >= MAX_ITER
// ---------------------------------------------------------------------------
module skeleton_writeback #(
  parameter int N        = 8,
  parameter int bitSize  = 6,
  parameter int MAX_ITER = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_pass,
  input  logic             in_valid,
  input  logic [bitSize:0] in_addr,
  input  logic [7:0]       in_data,
  input  logic [bitSize:0] rd_addr,
  output logic [7:0]       rd_data,
  output logic             busy,
  output logic             pass_done,
  output logic [bitSize:0] changed_count,
  output logic             converged,
  output logic [7:0]       iter_count,
  output logic             iter_limit_hit
);

  localparam int AW    = bitSize + 1;
  localparam int DEPTH = N * N;
  localparam int IW    = $clog2(DEPTH);
  // One bit wider than the address so DEPTH == 2^AW is representable.
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, COLLECT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   last_addr_q, last_addr_d;
  logic            last_vld_q, last_vld_d;
  logic [AW-1:0]   run_cnt_q, run_cnt_d;
  logic [AW-1:0]   changed_count_q, changed_count_d;
  logic            converged_q, converged_d;
  logic [7:0]      iter_count_q, iter_count_d;
  logic            iter_limit_q, iter_limit_d;
  logic            pass_done_q, pass_done_d;
  logic [7:0]      rd_data_q, rd_data_d;

  logic [7:0]      frame_mem [DEPTH];

  logic            accept;
  logic            wr_in_range;
  logic            rd_in_range;
  logic            wr_en;
  logic [7:0]      wr_data;
  logic [7:0]      wr_old;

  assign wr_in_range = {1'b0, in_addr} < DEPTH_W;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

`ifdef WB_BINARIZE_EN
  assign wr_data = (in_data != 8'h00) ? 8'hFF : 8'h00;
`else
  assign wr_data = in_data;
`endif

  // Old contents of the target pixel, read in the same cycle as the write.
  assign wr_old = wr_in_range ? frame_mem[in_addr[IW-1:0]] : 8'h00;
  assign wr_en  = accept && wr_in_range;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d         = state_q;
    last_addr_d     = last_addr_q;
    last_vld_d      = last_vld_q;
    run_cnt_d       = run_cnt_q;
    changed_count_d = changed_count_q;
    converged_d     = converged_q;
    iter_count_d    = iter_count_q;
    iter_limit_d    = iter_limit_q;
    pass_done_d     = 1'b0;
    accept          = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A sample coinciding with start_pass is deliberately not taken.
        if (start_pass) begin
          state_d    = ARMED;
          run_cnt_d  = '0;
          last_vld_d = 1'b0;
        end
      end
      ARMED: begin
        if (in_valid) begin
          state_d = COLLECT;
          accept  = 1'b1;
        end
      end
      COLLECT: begin
        if (in_valid) begin
          // Upstream holds each result for two clocks; drop the repeat.
          accept = !last_vld_q || (in_addr != last_addr_q);
        end else begin
          state_d         = IDLE;
          pass_done_d     = 1'b1;
          changed_count_d = run_cnt_q;
          converged_d     = (run_cnt_q == '0);
          iter_count_d    = (&iter_count_q) ? iter_count_q : iter_count_q + 8'd1;
          iter_limit_d    = iter_count_d >= 8'(MAX_ITER);
        end
      end
      default: state_d = IDLE;
    endcase

    // Out-of-range addresses still update the dedupe register, since the
    // upstream holds them for two clocks like any other result.
    if (accept) begin
      last_addr_d = in_addr;
      last_vld_d  = 1'b1;
      if (wr_in_range && (wr_data != wr_old) && !(&run_cnt_q))
        run_cnt_d = run_cnt_q + 1'b1;
    end

    rd_data_d = rd_in_range ? frame_mem[rd_addr[IW-1:0]] : 8'h00;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; this is also what makes the read port and the change
  // compare see the old pixel when the same address is written this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      last_addr_q     <= '0;
      last_vld_q      <= 1'b0;
      run_cnt_q       <= '0;
      changed_count_q <= '0;
      converged_q     <= 1'b0;
      iter_count_q    <= 8'd0;
      iter_limit_q    <= 1'b0;
      pass_done_q     <= 1'b0;
      rd_data_q       <= 8'h00;
    end else begin
      state_q         <= state_d;
      last_addr_q     <= last_addr_d;
      last_vld_q      <= last_vld_d;
      run_cnt_q       <= run_cnt_d;
      changed_count_q <= changed_count_d;
      converged_q     <= converged_d;
      iter_count_q    <= iter_count_d;
      iter_limit_q    <= iter_limit_d;
      pass_done_q     <= pass_done_d;
      rd_data_q       <= rd_data_d;
    end
  end

  // NOTE: the frame memory has no reset; a partial pass interrupted by reset
  // leaves its writes in place, and a reset-free array maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (wr_en) frame_mem[in_addr[IW-1:0]] <= wr_data;
  end

  assign rd_data        = rd_data_q;
  assign busy           = (state_q != IDLE);
  assign pass_done      = pass_done_q;
  assign changed_count  = changed_count_q;
  assign converged      = converged_q;
  assign iter_count     = iter_count_q;
  assign iter_limit_hit = iter_limit_q;

endmodule
